// File: rtl/py_sched_pkg.sv
// Shared types and constants for the P(Y)-code scheduler.
// Block width, FSM states and channel-index width helper.
package py_sched_pkg;

  localparam int BLK_W = 128;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/py_code_sched_asm.sv
// pcode_blk_asm: per-channel 128-bit P-code block assembler.
// Ports: clk/rst_n, i_bit/i_en bit strobe, i_clear_pend, i_clr_err,
//        o_buf held block, o_pend block waiting, o_ovf sticky drop.
module pcode_blk_asm
  import py_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  input  logic             i_en,
  input  logic             i_clear_pend,
  input  logic             i_clr_err,
  output logic [BLK_W-1:0] o_buf,
  output logic             o_pend,
  output logic             o_ovf
);

  logic [BLK_W-1:0] r_sr;
  logic [BLK_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_ovf;

  logic [BLK_W-1:0] w_blk;
  logic             w_done;
  logic             w_take;

  assign w_blk  = {r_sr[BLK_W-2:0], i_bit};
  assign w_done = i_en && (r_cnt == '1);
  // a slot freed by the FSM this very cycle still accepts the block
  assign w_take = w_done && (!r_pend || i_clear_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_buf  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_en) begin
        r_sr  <= w_blk;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_take) begin
        r_buf <= w_blk;
      end
      if (w_take) begin
        r_pend <= 1'b1;
      end else if (i_clear_pend) begin
        r_pend <= 1'b0;
      end
      if (w_done && !w_take) begin
        r_ovf <= 1'b1;
      end else if (i_clr_err) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_buf  = r_buf;
  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/py_code_sched.sv
// Round-robin scheduler sharing one AES-192 engine among P-code channels.
// Ports: P-code bit inputs, AES start/pt/ct/valid, P(Y) valid/ready out,
//        sticky ovf/timeout_err with clr_err; blk_cnt if PY_SCHED_STATS_EN.
module py_code_sched
  import py_sched_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int AES_TIMEOUT = 64,
  localparam int CW          = ch_w(NUM_CH)
) (
  input  logic                gps_clk_fast,
  input  logic                gps_rst_n,
  input  logic [NUM_CH-1:0]   p_code_in,
  input  logic [NUM_CH-1:0]   p_code_en,
  output logic                aes_start,
  output logic [BLK_W-1:0]    aes_pt,
  input  logic [BLK_W-1:0]    aes_ct,
  input  logic                aes_ct_valid,
  output logic [BLK_W-1:0]    py_code,
  output logic [CW-1:0]       py_ch,
  output logic                py_code_valid,
  input  logic                py_code_ready,
  output logic [NUM_CH-1:0]   ovf,
  output logic                timeout_err,
  input  logic                clr_err
`ifdef PY_SCHED_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] blk_cnt
`endif
);

  localparam int TW = $clog2(AES_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [CW-1:0]    r_g;
  logic [CW-1:0]    r_last;
  logic [BLK_W-1:0] r_pt;
  logic [TW-1:0]    r_tmr;
  logic [BLK_W-1:0] r_code;
  logic [CW-1:0]    r_ch;
  logic             r_tmo_err;

  logic [BLK_W-1:0] w_bufs [NUM_CH];
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_clr;
  logic             w_any;
  logic [CW-1:0]    w_grant;
  int               w_idx;
  logic             w_tmo;
  logic             w_hs;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_clr[i] = (r_state == ISSUE) && (r_g == CW'(i));
    pcode_blk_asm u_asm (
      .clk          (gps_clk_fast),
      .rst_n        (gps_rst_n),
      .i_bit        (p_code_in[i]),
      .i_en         (p_code_en[i]),
      .i_clear_pend (w_clr[i]),
      .i_clr_err    (clr_err),
      .o_buf        (w_bufs[i]),
      .o_pend       (w_pend[i]),
      .o_ovf        (ovf[i])
    );
  end

  // first pending channel at or after last+1, wrapping
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_last) + k) % NUM_CH;
      if (!w_any && w_pend[w_idx]) begin
        w_any   = 1'b1;
        w_grant = CW'(w_idx);
      end
    end
  end

  // a valid arriving on the deadline cycle still wins
  assign w_tmo = (r_state == WAIT) && !aes_ct_valid &&
                 (r_tmr == TW'(AES_TIMEOUT));
  assign w_hs  = (r_state == OUT) && py_code_ready;

  always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
    if (!gps_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_nxt = ISSUE;
      ISSUE:   w_nxt = WAIT;
      WAIT: begin
        if (aes_ct_valid) begin
          w_nxt = OUT;
        end else if (w_tmo) begin
          w_nxt = IDLE;
        end
      end
      OUT:     if (py_code_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
    if (!gps_rst_n) begin
      r_g       <= '0;
      r_last    <= CW'(NUM_CH - 1);
      r_pt      <= '0;
      r_tmr     <= '0;
      r_code    <= '0;
      r_ch      <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      // plaintext latched at grant so it stays put while buf refills
      if (r_state == IDLE && w_any) begin
        r_g  <= w_grant;
        r_pt <= w_bufs[w_grant];
      end
      if (r_state == ISSUE) begin
        r_last <= r_g;
        r_tmr  <= TW'(1);
      end else if (r_state == WAIT) begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (r_state == WAIT && aes_ct_valid) begin
        r_code <= aes_ct;
        r_ch   <= r_g;
      end
      if (w_tmo) begin
        r_tmo_err <= 1'b1;
      end else if (clr_err) begin
        r_tmo_err <= 1'b0;
      end
    end
  end

  assign aes_start     = (r_state == ISSUE);
  assign aes_pt        = r_pt;
  assign py_code       = r_code;
  assign py_ch         = r_ch;
  assign py_code_valid = (r_state == OUT);
  assign timeout_err   = r_tmo_err;

`ifdef PY_SCHED_STATS_EN
  logic [15:0] r_blk [NUM_CH];

  always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
    if (!gps_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_blk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_hs && r_ch == CW'(i)) begin
          r_blk[i] <= r_blk[i] + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    assign blk_cnt[i*16 +: 16] = r_blk[i];
  end
`endif

endmodule

// File: tb/tb_py_code_sched.sv
// Self-checking bench for py_code_sched with a behavioural AES model.
// Table of single-block vectors plus directed multi-cycle sequences.
module tb_py_code_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   p_in = '0;
  logic [3:0]   p_en = '0;
  logic         aes_start;
  logic [127:0] aes_pt;
  logic [127:0] aes_ct = '0;
  logic         aes_ct_valid = 1'b0;
  logic [127:0] py_code;
  logic [1:0]   py_ch;
  logic         py_valid;
  logic         py_ready = 1'b0;
  logic [3:0]   ovf;
  logic         tmo;
  logic         clr_err = 1'b0;
`ifdef PY_SCHED_STATS_EN
  logic [63:0]  blk_cnt;
`endif

  always #5 clk = ~clk;

  py_code_sched #(.NUM_CH(4), .AES_TIMEOUT(64)) dut (
    .gps_clk_fast  (clk),
    .gps_rst_n     (rst_n),
    .p_code_in     (p_in),
    .p_code_en     (p_en),
    .aes_start     (aes_start),
    .aes_pt        (aes_pt),
    .aes_ct        (aes_ct),
    .aes_ct_valid  (aes_ct_valid),
    .py_code       (py_code),
    .py_ch         (py_ch),
    .py_code_valid (py_valid),
    .py_code_ready (py_ready),
    .ovf           (ovf),
    .timeout_err   (tmo),
    .clr_err       (clr_err)
`ifdef PY_SCHED_STATS_EN
    ,
    .blk_cnt       (blk_cnt)
`endif
  );

  // engine model: fixed latency, returns ~pt; not tied to DUT reset
  logic         model_en = 1'b1;
  logic         busy = 1'b0;
  int           tcnt = 0;
  logic [127:0] ct_hold = '0;
  logic [127:0] model_pt = '0;
  int           starts = 0;
  always @(posedge clk) begin
    aes_ct_valid <= 1'b0;
    if (aes_start) starts <= starts + 1;
    if (aes_start && model_en) begin
      busy     <= 1'b1;
      tcnt     <= 1;
      ct_hold  <= ~aes_pt;
      model_pt <= aes_pt;
    end else if (busy) begin
      if (tcnt == 10) begin
        aes_ct_valid <= 1'b1;
        aes_ct       <= ct_hold;
        busy         <= 1'b0;
      end
      tcnt <= tcnt + 1;
    end
  end

  logic [1:0]   hs_ch [$];
  logic [127:0] hs_code [$];
  always @(posedge clk) begin
    if (rst_n && py_valid && py_ready) begin
      hs_ch.push_back(py_ch);
      hs_code.push_back(py_code);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic feed(input logic [3:0] m, input logic [127:0] d0,
                      input logic [127:0] d1, input logic [127:0] d2,
                      input logic [127:0] d3);
    for (int b = 127; b >= 0; b--) begin
      @(negedge clk);
      p_en = m;
      p_in = {d3[b], d2[b], d1[b], d0[b]};
    end
    @(negedge clk);
    p_en = '0;
    p_in = '0;
  endtask

  task automatic wait_valid(output logic ok, output logic lat1);
    logic prev;
    ok   = 1'b0;
    lat1 = 1'b0;
    prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (py_valid) begin
        ok   = 1'b1;
        lat1 = prev;
        break;
      end
      prev = aes_ct_valid;
      @(negedge clk);
    end
  endtask

  task automatic wait_hs(input int n, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (hs_ch.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int           ch;
    logic [127:0] data;
    int           hold;
    logic [127:0] exp_code;
    logic [1:0]   exp_ch;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic ok;
    logic lat1;
    int   s0;
    int   cyc;
    int   vcnt;
    logic [127:0] dd;

    vecs[0] = '{0, {128{1'b1}}, 3, 128'h0, 2'd0};
    vecs[1] = '{1, 128'h0123456789abcdef_fedcba9876543210, 0,
                128'hfedcba9876543210_0123456789abcdef, 2'd1};
    vecs[2] = '{3, 128'hdeadbeef_cafef00d_12345678_9abcdef0, 2,
                128'h21524110_35010ff2_edcba987_6543210f, 2'd3};
    vecs[3] = '{2, 128'h0, 1, {128{1'b1}}, 2'd2};
    vecs[4] = '{0, {32{4'ha}}, 0, {32{4'h5}}, 2'd0};

    #1;
    chk("rst_start", {127'd0, aes_start}, 128'd0);
    chk("rst_pt", aes_pt, 128'd0);
    chk("rst_code", py_code, 128'd0);
    chk("rst_misc", {py_ch, py_valid, ovf, tmo}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      s0 = starts;
      dd = vecs[i].data;
      feed(4'(1 << vecs[i].ch), dd, dd, dd, dd);
      wait_valid(ok, lat1);
      chk($sformatf("v%0d_valid", i), ok, 1);
      chk($sformatf("v%0d_lat", i), lat1, 1);
      chk($sformatf("v%0d_starts", i), starts - s0, 1);
      chk($sformatf("v%0d_pt", i), model_pt, vecs[i].data);
      chk($sformatf("v%0d_code", i), py_code, vecs[i].exp_code);
      chk($sformatf("v%0d_ch", i), py_ch, vecs[i].exp_ch);
      repeat (vecs[i].hold) @(negedge clk);
      chk($sformatf("v%0d_hold", i), {py_valid, py_code},
          {1'b1, vecs[i].exp_code});
      py_ready = 1'b1;
      @(negedge clk);
      py_ready = 1'b0;
      chk($sformatf("v%0d_drop", i), py_valid, 0);
    end

    // round robin from reset: 0,1,2,3 then 1,3
    do_reset();
    hs_ch.delete();
    hs_code.delete();
    py_ready = 1'b1;
    feed(4'hf, {32{4'h1}}, {32{4'h2}}, {32{4'h4}}, {32{4'h8}});
    wait_hs(4, ok);
    chk("rr_done", ok, 1);
    if (ok) begin
      chk("rr_ord", {hs_ch[0], hs_ch[1], hs_ch[2], hs_ch[3]},
          {2'd0, 2'd1, 2'd2, 2'd3});
      chk("rr_c0", hs_code[0], {32{4'he}});
      chk("rr_c3", hs_code[3], {32{4'h7}});
    end
    hs_ch.delete();
    hs_code.delete();
    feed(4'b1010, '0, {32{4'h2}}, '0, {32{4'h8}});
    wait_hs(2, ok);
    chk("rr2_done", ok, 1);
    if (ok) begin
      chk("rr2_ord", {hs_ch[0], hs_ch[1]}, {2'd1, 2'd3});
    end

    // overflow on ch2 while OUT is stalled
    repeat (5) @(negedge clk);
    py_ready = 1'b0;
    hs_ch.delete();
    hs_code.delete();
    feed(4'b0001, {32{4'h3}}, '0, '0, '0);
    feed(4'b0100, '0, '0, {32{4'hc}}, '0);
    chk("ovf_none", ovf, 4'b0000);
    feed(4'b0100, '0, '0, {32{4'h6}}, '0);
    chk("ovf_set", ovf, 4'b0100);
    py_ready = 1'b1;
    wait_hs(2, ok);
    chk("ovf_done", ok, 1);
    if (ok) begin
      chk("ovf_ord", {hs_ch[0], hs_ch[1]}, {2'd0, 2'd2});
      chk("ovf_code", hs_code[1], {32{4'h3}});
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovf_clr", ovf, 4'b0000);

    // timeout: last=2, so ch3 goes first and expires, then ch1
    repeat (5) @(negedge clk);
    hs_ch.delete();
    hs_code.delete();
    model_en = 1'b0;
    feed(4'b1010, '0, {32{4'h9}}, '0, {32{4'h5}});
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (aes_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tmo_issue", ok, 1);
    cyc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cyc++;
      if (tmo) break;
    end
    model_en = 1'b1;
    chk("tmo_cycles", cyc, 65);
    wait_hs(1, ok);
    chk("tmo_next", ok, 1);
    if (ok) begin
      chk("tmo_ch", hs_ch[0], 2'd1);
      chk("tmo_code", hs_code[0], {32{4'h6}});
    end
    chk("tmo_sticky", tmo, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("tmo_clr", tmo, 0);

    // reset while waiting on the engine
    repeat (5) @(negedge clk);
    feed(4'b0001, {128{1'b1}}, '0, '0, '0);
    for (int c = 0; c < 20; c++) begin
      if (aes_start) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wrst_pt", aes_pt, 128'd0);
    chk("wrst_misc", {aes_start, py_valid, py_ch, ovf, tmo}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (py_valid) vcnt++;
    end
    chk("wrst_noout", vcnt, 0);

`ifdef PY_SCHED_STATS_EN
    chk("st_zero", blk_cnt, 128'd0);
    py_ready = 1'b1;
    hs_ch.delete();
    hs_code.delete();
    for (int k = 0; k < 5; k++) begin
      feed(4'b0010, '0, 128'(k + 1), '0, '0);
      wait_hs(k + 1, ok);
    end
    @(negedge clk);
    chk("st_cnt", blk_cnt, {16'd0, 16'd0, 16'd5, 16'd0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
